// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter
//
// Two-requester round-robin arbiter and sequencer for the DDR controller's
// simple memory command port. It accepts one transaction at a time, issues a
// one-cycle read or write strobe, and waits for mem_ack with a timeout. It then
// returns the response to the requester that was granted. At most one
// transaction is outstanding, so the response bus (rsp_rdata/rsp_err) is
// shared and qualified by rsp0_valid/rsp1_valid.
//
// Ports:
//   ACLK, ARESETN              clock, synchronous active-low reset
//   reqN_valid/ready           request handshake (ready is a one-cycle accept)
//   reqN_we/addr/wdata/wstrb   request payload, sampled on the accept cycle
//   rspN_valid/ready           response handshake for requester N
//   rsp_rdata, rsp_err         shared response payload (err = timeout)
//   mem_wr_en, mem_rd_en       one-cycle command strobes
//   mem_add/wdata/wstrb        latched command payload, held until next accept
//   mem_rdata, mem_ack         completion from the memory side
module ddr_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                req0_valid,
    input  logic                req1_valid,
    output logic                req0_ready,
    output logic                req1_ready,
    input  logic                req0_we,
    input  logic                req1_we,
    input  logic [ADDR_W-1:0]   req0_addr,
    input  logic [ADDR_W-1:0]   req1_addr,
    input  logic [DATA_W-1:0]   req0_wdata,
    input  logic [DATA_W-1:0]   req1_wdata,
    input  logic [DATA_W/8-1:0] req0_wstrb,
    input  logic [DATA_W/8-1:0] req1_wstrb,
    output logic                rsp0_valid,
    output logic                rsp1_valid,
    input  logic                rsp0_ready,
    input  logic                rsp1_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                mem_wr_en,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_add,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack
);

    localparam int STRB_W = DATA_W / 8;
    // Timeout fires in the WAIT cycle whose increment would make the
    // counter equal TIMEOUT, i.e. after exactly TIMEOUT WAIT cycles.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic                grant_reg, grant_next;
    logic                last_grant_reg, last_grant_next;
    logic                we_reg, we_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [STRB_W-1:0]   wstrb_reg, wstrb_next;
    logic [15:0]         cnt_reg, cnt_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic                err_reg, err_next;

    logic                winner;
    logic                accept;
    logic                rsp_taken;

    // Winner selection: a lone requester wins; on contention the requester
    // that was not granted last time wins.
    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid) begin
            winner = ~last_grant_reg;
        end else if (req1_valid) begin
            winner = 1'b1;
        end
    end

    // Ready is gated by ARESETN so nothing appears accepted while the block
    // is being held in reset.
    assign accept    = (state_reg == IDLE) && (req0_valid || req1_valid) && ARESETN;
    assign rsp_taken = grant_reg ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        we_next         = we_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        wstrb_next      = wstrb_reg;
        cnt_next        = cnt_reg;
        rdata_next      = rdata_reg;
        err_next        = err_reg;

        req0_ready      = 1'b0;
        req1_ready      = 1'b0;
        mem_wr_en       = 1'b0;
        mem_rd_en       = 1'b0;
        rsp0_valid      = 1'b0;
        rsp1_valid      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    req0_ready = ~winner;
                    req1_ready = winner;
                    grant_next = winner;
                    we_next    = winner ? req1_we    : req0_we;
                    addr_next  = winner ? req1_addr  : req0_addr;
                    wdata_next = winner ? req1_wdata : req0_wdata;
                    wstrb_next = winner ? req1_wstrb : req0_wstrb;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // mem_ack during the strobe cycle is deliberately ignored.
                mem_wr_en  = we_reg;
                mem_rd_en  = ~we_reg;
                cnt_next   = '0;
                state_next = WAIT;
            end
            WAIT: begin
                if (mem_ack) begin
                    // Ack takes priority over a coincident timeout.
                    rdata_next = we_reg ? '0 : mem_rdata;
                    err_next   = 1'b0;
                    state_next = RESP;
                end else if (cnt_reg == CNT_LAST) begin
                    cnt_next   = cnt_reg + 16'd1;
                    rdata_next = '0;
                    err_next   = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next   = cnt_reg + 16'd1;
                end
            end
            RESP: begin
                rsp0_valid = ~grant_reg;
                rsp1_valid = grant_reg;
                if (rsp_taken) begin
                    last_grant_next = grant_reg;
                    state_next      = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_reg      <= IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            wstrb_reg      <= '0;
            cnt_reg        <= '0;
            rdata_reg      <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            wstrb_reg      <= wstrb_next;
            cnt_reg        <= cnt_next;
            rdata_reg      <= rdata_next;
            err_reg        <= err_next;
        end
    end

    assign mem_add   = addr_reg;
    assign mem_wdata = wdata_reg;
    assign mem_wstrb = wstrb_reg;
    assign rsp_rdata = rdata_reg;
    assign rsp_err   = err_reg;

endmodule
